// File: rtl/avalon_mem_responder_pkg.sv
// rtl/avalon_mem_responder_pkg.sv - shared types and helpers for the Avalon-MM memory responder
package avalon_mem_responder_pkg;

  typedef enum logic {
    RESP_IDLE,
    RESP_STALL
  } responder_state_t;

  localparam logic [31:0] RESP_ERR_DATA = 32'hDEAD_BEEF;
  localparam int          CNT_W         = 8;

  function automatic logic [31:0] apply_byteenable(input logic [31:0] old_word,
                                                   input logic [31:0] new_word,
                                                   input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/avalon_mem_responder_wait_lfsr.sv
// rtl/avalon_mem_responder_wait_lfsr.sv - 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1) for random wait states
module wait_lfsr (
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  input  logic [7:0] seed,
  output logic [7:0] value
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= seed;
    end else if (advance) begin
      value <= value[0] ? ({1'b0, value[7:1]} ^ 8'hB8) : {1'b0, value[7:1]};
    end
  end

endmodule

// File: rtl/avalon_mem_responder.sv
// rtl/avalon_mem_responder.sv - Avalon-MM RAM responder with fixed/random wait states and error flag
module avalon_mem_responder
  import avalon_mem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC0_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter int          WAIT_MODE   = 0,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        error
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_W30 = 30'(DEPTH_WORDS);

  responder_state_t   state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   target_q, target, fresh_target;
  logic [7:0]         lfsr_value;
  logic               req, accept;
  logic [29:0]        word_off;
  logic [AW-1:0]      idx;
  logic               in_range, misaligned, conflict;
  logic [31:0]        mem [DEPTH_WORDS];

  // Gating req with reset keeps waitrequest low and blocks any accept while reset is held.
  assign req        = reset && (read || write);
  assign word_off   = address[31:2] - BASE_ADDR[31:2];
  assign idx        = word_off[AW-1:0];
  assign in_range   = (address >= BASE_ADDR) && (word_off < DEPTH_W30);
  assign misaligned = (address[1:0] != 2'b00);
  assign conflict   = read && write;

  assign fresh_target = (WAIT_MODE == 1) ? (lfsr_value & 8'h03) : CNT_W'(WAIT_CYCLES);

  wait_lfsr u_wait_lfsr (
    .clk    (clk),
    .reset  (reset),
    .advance(accept),
    .seed   (LFSR_SEED),
    .value  (lfsr_value)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    target      = (state_q == RESP_IDLE) ? fresh_target : target_q;
    waitrequest = req && (cnt_q != target);
    accept      = req && !waitrequest;
    if (req && waitrequest) begin
      state_d = RESP_STALL;
      cnt_d   = cnt_q + 1'b1;
    end else begin
      state_d = RESP_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RESP_IDLE;
      cnt_q    <= '0;
      target_q <= '0;
      readdata <= '0;
      error    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target;
      if (accept && read) begin
        if (conflict)       readdata <= RESP_ERR_DATA;
        else if (!in_range) readdata <= '0;
        else                readdata <= mem[idx];
      end
      if (accept && (conflict || !in_range || misaligned)) error <= 1'b1;
    end
  end

  // RAM contents survive reset; only accepted, legal writes modify a word.
  always_ff @(posedge clk) begin
    if (accept && write && !read && in_range) begin
      mem[idx] <= apply_byteenable(mem[idx], writedata, byteenable);
    end
  end

endmodule

// File: tb/tb_avalon_mem_responder.sv
// tb/tb_avalon_mem_responder.sv - directed self-checking bench for avalon_mem_responder
module tb_avalon_mem_responder;

  localparam logic [31:0] BASE = 32'hBFC0_0000;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      address, writedata;
  logic [3:0]       byteenable;
  logic [2:0]       rd, wr, wreq, err;
  logic [2:0][31:0] rdata;
  int               n_tests = 0;
  int               n_fail  = 0;
  int               st;
  logic [7:0]       lfsr_m;
  logic [31:0]      model [16];
  logic [31:0]      d;
  logic [3:0]       be;
  int               k, op;

  always #5 clk = ~clk;

  avalon_mem_responder #(.WAIT_CYCLES(2)) u_fix2 (
    .clk(clk), .reset(reset), .address(address), .read(rd[0]), .write(wr[0]),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(wreq[0]),
    .readdata(rdata[0]), .error(err[0]));

  avalon_mem_responder #(.WAIT_CYCLES(0)) u_fix0 (
    .clk(clk), .reset(reset), .address(address), .read(rd[1]), .write(wr[1]),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(wreq[1]),
    .readdata(rdata[1]), .error(err[1]));

  avalon_mem_responder #(.WAIT_MODE(1), .LFSR_SEED(8'hA5)) u_rand (
    .clk(clk), .reset(reset), .address(address), .read(rd[2]), .write(wr[2]),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(wreq[2]),
    .readdata(rdata[2]), .error(err[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request on instance s; st returns the number of cycles waitrequest was seen high.
  task automatic bus(input int s, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] dat, input logic [3:0] ben, output int stalls);
    stalls = 0;
    @(negedge clk);
    address = a; writedata = dat; byteenable = ben; rd[s] = r; wr[s] = w;
    #1;
    while (wreq[s] && stalls < 20) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    chk("bus_timeout", 32'(stalls < 20), 32'd1);
    @(posedge clk);
    #1;
    rd[s] = 1'b0; wr[s] = 1'b0;
  endtask

  initial begin
    reset = 1'b0; rd = '0; wr = '0;
    address = BASE; writedata = '0; byteenable = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      chk("rst_waitrequest", 32'(wreq[s]), 32'd0);
      chk("rst_readdata", rdata[s], 32'd0);
      chk("rst_error", 32'(err[s]), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;

    // fixed 2-cycle stall, read of preloaded word
    bus(0, 1'b0, 1'b1, BASE, 32'h1234_5678, 4'hF, st);
    chk("t1_wr_stall", st, 2);
    bus(0, 1'b1, 1'b0, BASE, 32'h0, 4'h0, st);
    chk("t1_rd_stall", st, 2);
    chk("t1_rdata", rdata[0], 32'h1234_5678);

    // byteenable merge; writes leave readdata alone
    bus(0, 1'b0, 1'b1, BASE + 4, 32'h0, 4'hF, st);
    bus(0, 1'b0, 1'b1, BASE + 4, 32'hAABB_CCDD, 4'b0101, st);
    chk("t2_rdata_hold", rdata[0], 32'h1234_5678);
    bus(0, 1'b1, 1'b0, BASE + 4, 32'h0, 4'h0, st);
    chk("t2_rdata", rdata[0], 32'h00BB_00DD);
    chk("t2_error", 32'(err[0]), 32'd0);

    // out-of-range read, then read+write conflict
    bus(0, 1'b1, 1'b0, BASE + 32'd4096, 32'h0, 4'h0, st);
    chk("t4_oor_stall", st, 2);
    chk("t4_oor_rdata", rdata[0], 32'h0);
    chk("t4_oor_error", 32'(err[0]), 32'd1);
    bus(0, 1'b1, 1'b1, BASE + 4, 32'hFFFF_FFFF, 4'hF, st);
    chk("t4_conflict_rdata", rdata[0], 32'hDEAD_BEEF);
    bus(0, 1'b1, 1'b0, BASE + 4, 32'h0, 4'h0, st);
    chk("t4_conflict_noram", rdata[0], 32'h00BB_00DD);
    chk("t4_error_sticky", 32'(err[0]), 32'd1);

    // zero wait states, back-to-back write/read
    bus(1, 1'b0, 1'b1, BASE + 20, 32'hCAFE_F00D, 4'hF, st);
    chk("t3_wr_stall", st, 0);
    bus(1, 1'b1, 1'b0, BASE + 20, 32'h0, 4'h0, st);
    chk("t3_rd_stall", st, 0);
    chk("t3_rdata", rdata[1], 32'hCAFE_F00D);
    bus(1, 1'b0, 1'b1, BASE + 20, 32'h0, 4'b0000, st);
    bus(1, 1'b1, 1'b0, BASE + 20, 32'h0, 4'h0, st);
    chk("t3_be0_rdata", rdata[1], 32'hCAFE_F00D);
    chk("t3_be0_error", 32'(err[1]), 32'd0);
    bus(1, 1'b0, 1'b1, BASE + 21, 32'h0000_0099, 4'b0001, st);
    bus(1, 1'b1, 1'b0, BASE + 20, 32'h0, 4'h0, st);
    chk("t3_misalign_rdata", rdata[1], 32'hCAFE_F099);
    chk("t3_misalign_error", 32'(err[1]), 32'd1);

    // withdraw mid-stall, then a full fresh stall
    @(negedge clk);
    address = BASE; rd[0] = 1'b1;
    #1;
    chk("t5_drop_wreq0", 32'(wreq[0]), 32'd1);
    @(negedge clk);
    #1;
    chk("t5_drop_wreq1", 32'(wreq[0]), 32'd1);
    rd[0] = 1'b0;
    @(negedge clk);
    #1;
    chk("t5_drop_rdata", rdata[0], 32'h00BB_00DD);
    bus(0, 1'b1, 1'b0, BASE, 32'h0, 4'h0, st);
    chk("t5_fresh_stall", st, 2);
    chk("t5_fresh_rdata", rdata[0], 32'h1234_5678);

    // asynchronous reset in the middle of a stall
    @(negedge clk);
    address = BASE + 4; rd[0] = 1'b1;
    #1;
    chk("t5_rst_pre_wreq", 32'(wreq[0]), 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_rst_wreq", 32'(wreq[0]), 32'd0);
    chk("t5_rst_rdata", rdata[0], 32'h0);
    chk("t5_rst_error0", 32'(err[0]), 32'd0);
    chk("t5_rst_error1", 32'(err[1]), 32'd0);
    rd[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // random wait states against an LFSR and memory scoreboard
    lfsr_m = 8'hA5;
    for (int i = 0; i < 64; i++) begin
      if (i < 16) begin
        op = 1; k = i; be = 4'hF;
      end else begin
        op = int'($urandom_range(0, 1)); k = int'($urandom_range(0, 15)); be = 4'($urandom_range(0, 15));
      end
      d = $urandom;
      bus(2, op == 0, op == 1, BASE + 32'(4 * k), d, be, st);
      chk("t6_stall", st, 32'(lfsr_m[1:0]));
      lfsr_m = lfsr_m[0] ? ({1'b0, lfsr_m[7:1]} ^ 8'hB8) : {1'b0, lfsr_m[7:1]};
      if (op == 1) begin
        for (int b = 0; b < 4; b++) if (be[b]) model[k][8*b +: 8] = d[8*b +: 8];
      end else begin
        chk("t6_rdata", rdata[2], model[k]);
      end
    end
    chk("t6_error", 32'(err[2]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
